// File: rtl/simon_byte_loader.sv
// Byte-stream front end for the SIMON control stage: assembles framed bytes into
// a 2N-bit block or an M*N-bit key and holds it until the control stage acks.
module simon_byte_loader #(
    parameter int N = 16,
    parameter int M = 4
) (
    input  logic                clk,
    input  logic                R,
    input  logic [7:0]          byteIN,
    input  logic                byteValid,
    output logic                byteReady,
    input  logic                loadData,
    input  logic                loadKey,
    output logic                newData,
    output logic                newKey,
    output logic [1:0][N-1:0]   blockOUT,
    output logic [M-1:0][N-1:0] KEY,
    output logic [7:0]          infoOUT,
    output logic [7:0]          countOUT,
    output logic                error
);

    localparam int DB   = 2 * N / 8;
    localparam int KB   = M * N / 8;
    localparam int SW   = (M * N > 2 * N) ? M * N : 2 * N;
    localparam int MAXB = (KB > DB) ? KB : DB;
    localparam int CW   = $clog2(MAXB + 1);

    // LOAD is the one-cycle PRESENT entry step that copies the shadow to the outputs.
    typedef enum logic [1:0] {IDLE, COLLECT, LOAD, PRESENT} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [7:0]      r_hdr;
    logic [SW-1:0]   r_shadow;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_lastIdx;
    logic            w_xfer;
    logic            w_hdrAccept;
    logic            w_reject;
    logic            w_shift;
    logic            w_ack;

    assign w_xfer    = byteValid && byteReady;
    assign w_lastIdx = r_hdr[7] ? CW'(KB - 1) : CW'(DB - 1);

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_hdrAccept = 1'b0;
        w_reject    = 1'b0;
        w_shift     = 1'b0;
        w_ack       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    if (byteIN[6]) begin
                        w_reject = 1'b1;
                    end else begin
                        w_hdrAccept = 1'b1;
                        w_next      = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (w_xfer) begin
                    w_shift = 1'b1;
                    if (r_cnt == w_lastIdx) begin
                        w_next = LOAD;
                    end
                end
            end
            LOAD: begin
                w_next = PRESENT;
            end
            PRESENT: begin
                if ((r_hdr[7] && loadKey) || (!r_hdr[7] && loadData)) begin
                    w_ack  = 1'b1;
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // byteReady is registered from the next state so it is low during reset.
    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            byteReady <= 1'b0;
            error     <= 1'b0;
            newData   <= 1'b0;
            newKey    <= 1'b0;
            blockOUT  <= '0;
            KEY       <= '0;
            infoOUT   <= 8'd0;
            countOUT  <= 8'd0;
            r_hdr     <= 8'd0;
            r_shadow  <= '0;
            r_cnt     <= '0;
        end else begin
            byteReady <= (w_next == IDLE) || (w_next == COLLECT);
            error     <= w_reject;
            if (w_hdrAccept) begin
                r_hdr <= byteIN;
                r_cnt <= '0;
            end
            if (w_shift) begin
                r_shadow <= {r_shadow[SW-9:0], byteIN};
                r_cnt    <= r_cnt + 1'b1;
            end
            if (r_state == LOAD) begin
                infoOUT <= r_hdr;
                if (r_hdr[7]) begin
                    KEY    <= r_shadow[M*N-1:0];
                    newKey <= 1'b1;
                end else begin
                    blockOUT <= r_shadow[2*N-1:0];
                    countOUT <= countOUT + 8'd1;
                    newData  <= 1'b1;
                end
            end
            if (w_ack) begin
                newData <= 1'b0;
                newKey  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_simon_byte_loader.sv
// Self-checking bench for simon_byte_loader: table vectors, random frames against
// a byte-list reference model, and hand sequences for ack, error, reset and wrap.
module tb_simon_byte_loader;

    localparam int N = 16;
    localparam int M = 4;

    logic                clk = 1'b0;
    logic                R;
    logic [7:0]          byteIN;
    logic                byteValid;
    logic                byteReady;
    logic                loadData;
    logic                loadKey;
    logic                newData;
    logic                newKey;
    logic [1:0][N-1:0]   blockOUT;
    logic [M-1:0][N-1:0] KEY;
    logic [7:0]          infoOUT;
    logic [7:0]          countOUT;
    logic                error;

    int errors = 0;
    int checks = 0;

    logic [7:0]  expCount;
    logic [31:0] expBlock;
    logic [63:0] expKey;
    logic [7:0]  expInfo;
    logic        expIsKey;
    logic        ackNoise;

    typedef struct {
        logic [7:0]  hdr;
        logic [63:0] payload;
        int          n;
        logic [63:0] expVal;
    } vec_t;

    vec_t vecs[5];

    simon_byte_loader #(.N(N), .M(M)) dut (
        .clk(clk), .R(R), .byteIN(byteIN), .byteValid(byteValid), .byteReady(byteReady),
        .loadData(loadData), .loadKey(loadKey), .newData(newData), .newKey(newKey),
        .blockOUT(blockOUT), .KEY(KEY), .infoOUT(infoOUT), .countOUT(countOUT), .error(error)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Waits (bounded) for byteReady, then transfers one byte on the next posedge.
    task automatic sendByte(input logic [7:0] b, input int gap);
        int waitCnt;
        waitCnt = 0;
        repeat (gap) @(negedge clk);
        while (!byteReady && waitCnt < 50) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!byteReady) begin
            checks++;
            errors++;
            $display("[TB] FAIL readyTimeout: got byteReady=0 expected 1 within 50 cycles");
        end
        byteIN    = b;
        byteValid = 1'b1;
        if (ackNoise) begin
            loadData = 1'($urandom);
            loadKey  = 1'($urandom);
        end
        @(negedge clk);
        byteValid = 1'b0;
        byteIN    = 8'($urandom);
    endtask

    // Sends a frame and updates the reference model from the byte list.
    task automatic applyStimulus(input logic [7:0] hdr, input logic [63:0] payload,
                                 input int n, input int maxGap);
        logic [63:0] v;
        logic [7:0]  b;
        v = 64'd0;
        sendByte(hdr, $urandom_range(maxGap, 0));
        for (int i = 0; i < n; i++) begin
            b = payload[8*(n-1-i) +: 8];
            v = v * 256 + 64'(b);
            sendByte(b, $urandom_range(maxGap, 0));
        end
        expIsKey = hdr[7];
        expInfo  = hdr;
        if (hdr[7]) begin
            expKey = v;
        end else begin
            expBlock = v[31:0];
            expCount = expCount + 8'd1;
        end
    endtask

    task automatic checkPresent();
        loadData = 1'b0;
        loadKey  = 1'b0;
        checkOutput("flagsBeforeLatency", {62'd0, newData, newKey}, 64'd0);
        checkOutput("readyAfterLast", byteReady, 0);
        @(negedge clk);
        checkOutput("flags", {62'd0, newData, newKey}, expIsKey ? 64'd1 : 64'd2);
        checkOutput("blockOUT", blockOUT, expBlock);
        checkOutput("KEY", KEY, expKey);
        checkOutput("infoOUT", infoOUT, expInfo);
        checkOutput("countOUT", countOUT, expCount);
        checkOutput("readyPresent", byteReady, 0);
    endtask

    task automatic ackFrame();
        if (expIsKey) loadKey = 1'b1;
        else          loadData = 1'b1;
        @(negedge clk);
        loadData = 1'b0;
        loadKey  = 1'b0;
        checkOutput("flagsAfterAck", {62'd0, newData, newKey}, 64'd0);
        checkOutput("readyAfterAck", byteReady, 1);
    endtask

    task automatic runFrame(input logic [7:0] hdr, input logic [63:0] payload,
                            input int n, input int maxGap);
        applyStimulus(hdr, payload, n, maxGap);
        checkPresent();
        ackFrame();
    endtask

    task automatic checkRejected(input logic [7:0] hdr);
        sendByte(hdr, 0);
        checkOutput("errorPulse", error, 1);
        checkOutput("readyAfterReject", byteReady, 1);
        @(negedge clk);
        checkOutput("errorOneCycle", error, 0);
        checkOutput("flagsAfterReject", {62'd0, newData, newKey}, 64'd0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_ready"}, byteReady, 0);
        checkOutput({tag, "_flags"}, {61'd0, newData, newKey, error}, 64'd0);
        checkOutput({tag, "_block"}, blockOUT, 0);
        checkOutput({tag, "_key"}, KEY, 0);
        checkOutput({tag, "_info"}, infoOUT, 0);
        checkOutput({tag, "_count"}, countOUT, 0);
    endtask

    initial begin
        logic        isKey;
        logic [7:0]  hdr;
        logic [63:0] pay;

        R = 1'b1; byteIN = 8'd0; byteValid = 1'b0; loadData = 1'b0; loadKey = 1'b0;
        ackNoise = 1'b0;
        expCount = 8'd0; expBlock = 32'd0; expKey = 64'd0; expInfo = 8'd0; expIsKey = 1'b0;

        vecs[0] = '{hdr: 8'h05, payload: 64'h0000_0000_0123_4567, n: 4, expVal: 64'h0123_4567};
        vecs[1] = '{hdr: 8'h80, payload: 64'h1918_1110_0908_0100, n: 8, expVal: 64'h1918_1110_0908_0100};
        vecs[2] = '{hdr: 8'h00, payload: 64'h0000_0000_AABB_CCDD, n: 4, expVal: 64'hAABB_CCDD};
        vecs[3] = '{hdr: 8'h3F, payload: 64'h0000_0000_FF00_FF00, n: 4, expVal: 64'hFF00_FF00};
        vecs[4] = '{hdr: 8'hBF, payload: 64'hDEAD_BEEF_0011_2233, n: 8, expVal: 64'hDEAD_BEEF_0011_2233};

        repeat (3) @(negedge clk);
        checkResetState("reset");
        R = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            runFrame(vecs[i].hdr, vecs[i].payload, vecs[i].n, i);
            if (vecs[i].hdr[7]) checkOutput("tableKey", KEY, vecs[i].expVal);
            else                checkOutput("tableBlock", {32'd0, blockOUT}, vecs[i].expVal);
        end

        // Ack handling: long hold, a wrong ack, then the right one.
        applyStimulus(8'h05, 64'h0123_4567, 4, 0);
        checkPresent();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("holdFlags", {62'd0, newData, newKey}, 64'd2);
            checkOutput("holdBlock", blockOUT, 64'h0123_4567);
        end
        loadKey = 1'b1;
        @(negedge clk);
        loadKey = 1'b0;
        checkOutput("wrongAckFlags", {62'd0, newData, newKey}, 64'd2);
        checkOutput("wrongAckReady", byteReady, 0);
        checkOutput("wrongAckBlock", blockOUT, 64'h0123_4567);
        ackFrame();

        // Rejected headers, then a stalled frame.
        checkRejected(8'h40);
        checkRejected(8'hC5);
        runFrame(8'h00, 64'hAABB_CCDD, 4, 4);
        checkOutput("afterRejectBlock", blockOUT, 64'hAABB_CCDD);

        // Random frames with random stalls and spurious acks outside PRESENT.
        ackNoise = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(4, 0) == 0) begin
                ackNoise = 1'b0;
                loadData = 1'b0;
                loadKey  = 1'b0;
                checkRejected({1'($urandom), 1'b1, 6'($urandom)});
                ackNoise = 1'b1;
            end
            isKey = 1'($urandom);
            hdr   = {isKey, 1'b0, 6'($urandom)};
            pay   = {$urandom, $urandom};
            runFrame(hdr, pay, isKey ? 8 : 4, 3);
        end
        ackNoise = 1'b0;

        // Reset mid-frame discards the partial frame and clears everything.
        sendByte(8'h00, 0);
        sendByte(8'h12, 0);
        sendByte(8'h34, 0);
        R = 1'b1;
        #1;
        checkResetState("midReset");
        @(negedge clk);
        R = 1'b0;
        expCount = 8'd0; expBlock = 32'd0; expKey = 64'd0;
        runFrame(8'h00, 64'h1122_3344, 4, 0);
        checkOutput("freshCount", countOUT, 8'h01);

        // Count wrap: 256 data frames since reset.
        for (int i = 0; i < 255; i++) begin
            runFrame({2'b00, 6'($urandom)}, {32'd0, $urandom}, 4, 0);
            if (i == 253) checkOutput("count255", countOUT, 8'hFF);
        end
        checkOutput("wrapZero", countOUT, 8'h00);
        checkOutput("wrapKeyUntouched", KEY, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/simon_byte_loader.md
Name: simon_byte_loader

Overview:
- Upstream feeder for the SIMON control stage.
- Accepts a byte-wide stream from the host interface and assembles framed bytes into either a 2N-bit plaintext/ciphertext block or an M*N-bit key.
- Presents the assembled word with newData/newKey plus info and count bytes, and holds it until the control stage acknowledges with loadData/loadKey.

Parameters:
- N, 16, SIMON word size in bits; must be a multiple of 8.
- M, 4, number of key words.

Ports:
- clk  input  1  system clock, all logic on posedge.
- R  input  1  asynchronous reset, active-high.
- byteIN  input  8  incoming stream byte.
- byteValid  input  1  byteIN valid this cycle.
- byteReady  output  1  loader can accept a byte this cycle.
- loadData  input  1  control stage has taken blockOUT.
- loadKey  input  1  control stage has taken KEY.
- newData  output  1  blockOUT valid, awaiting loadData.
- newKey  output  1  KEY valid, awaiting loadKey.
- blockOUT  output  2 x N  assembled block; [1] is the upper word.
- KEY  output  M x N  assembled key; [M-1] is the most significant word.
- infoOUT  output  8  header byte of the presented frame.
- countOUT  output  8  sequence number of the presented data block.
- error  output  1  one-cycle pulse on a rejected header.

Behaviour:
- Reset (R high, asynchronous):
  - byteReady=0; newData=0; newKey=0; error=0.
  - blockOUT=0; KEY=0; infoOUT=0; countOUT=0.
  - Byte counter=0; state=IDLE.
  - Reset mid-frame discards any partial frame with no output.
- Byte transfer occurs on a posedge with byteValid && byteReady. byteReady=1 in IDLE and COLLECT, 0 in PRESENT.
- Frame format:
  - Header byte: bit7=1 means key frame, 0 means data frame. bit6 is reserved and must be 0. bits[5:0] are user info.
  - Payload follows, MSB-first: 2N/8 bytes for data, M*N/8 bytes for key.
- IDLE:
  - On transfer with bit6=0: capture header into a shadow register, clear the byte counter, go to COLLECT.
  - On transfer with bit6=1: pulse error for 1 cycle, drop the byte, stay in IDLE.
- COLLECT:
  - Each transfer shifts byteIN into the LSB end of the target shadow register (first byte ends up most significant) and increments the byte counter.
  - On the final payload byte go to PRESENT.
  - byteValid low stalls the FSM indefinitely; there is no timeout.
- PRESENT:
  - Data frame:
    - Entry: copy shadow to blockOUT, header to infoOUT, countOUT+1 to countOUT (8-bit, wraps 255 to 0), assert newData.
  - Key frame:
    - Entry: copy shadow to KEY and header to infoOUT; countOUT is unchanged.
    - Assert newKey.
  - Latency: newData/newKey rise on the posedge after the edge that accepted the last payload byte.
  - Hold outputs stable until the matching ack (loadData for data, loadKey for key) is sampled high. On that edge drop newData/newKey and return to IDLE.
  - A non-matching ack is ignored. Any ack outside PRESENT is ignored.
- Registers:
  - blockOUT and KEY change only on PRESENT entry.
  - A key frame never disturbs blockOUT, and a data frame never disturbs KEY.
- newData and newKey are never high together.
- One frame in flight: a new header cannot be accepted until the ack, so back-to-back frames cost at least 1 PRESENT cycle each.

Test Plan:
- Data frame: bytes 05 01 23 45 67 -> newData rises 1 cycle after byte 67; blockOUT[1]=0x0123, blockOUT[0]=0x4567; infoOUT=0x05; countOUT=0x01; byteReady=0 until loadData.
- Key frame: bytes 80 19 18 11 10 09 08 01 00 -> newKey=1; KEY[3..0]=0x1918,0x1110,0x0908,0x0100; infoOUT=0x80; countOUT unchanged; blockOUT unchanged.
- Ack handling:
  - Hold loadData low 5 cycles, then pulse loadKey, then loadData -> outputs stable throughout; loadKey ignored; newData falls on the loadData edge; byteReady=1 the next cycle.
- Rejected header and stalls:
  - Header 0x40 -> error=1 for exactly 1 cycle; state stays IDLE.
  - Following frame 00 AA BB CC DD -> blockOUT={0xAABB,0xCCDD}.
  - byteValid gaps inside the frame produce no change in result.
- Reset mid-frame: header 00 plus 2 payload bytes, assert R -> all outputs 0 immediately; a fresh frame afterwards yields countOUT=0x01.
- Count wrap: 256 acknowledged data frames -> countOUT runs 0x01 to 0xFF, then 0x00 on the 256th.
